mem_display: RTL

MEM_DISPLAY -- requirements
Module: mem_display

---
 rtl/mem_display_pkg.sv | 22 ++
 rtl/hex_to_seg7.sv | 18 +
 rtl/mem_display.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_display_pkg.sv
// Shared seven-segment constants for the memory display: hex glyph table,
// blank/dash patterns, digit count and the one-cold digit-enable helper.
package mem_display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] AN_RESET  = 8'hFE;

    // Active-low {dp,g,f,e,d,c,b,a}, dp off; entry [n] is the glyph for nibble n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment decoder with optional decimal point.
// Zero latency; no handshake.
module hex_to_seg7
    import mem_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_on_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = HEX_SEG[nibble_i];
        if (dp_on_i) begin
            seg_o[7] = 1'b0;
        end
    end

endmodule

// File: rtl/mem_display.sv
// Captures BRAM read data READ_LATENCY cycles after the address settles and scans
// address/data onto an 8-digit display; seg/an registered; no backpressure.
module mem_display
    import mem_display_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int DWELL_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] bram_addr,
    input  logic [31:0] bram_dout,
    input  logic        half_sel,
    input  logic [1:0]  byte_sel,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic [7:0]  led,
    output logic        data_valid
);

    localparam int DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]         WAIT_LOAD  = 3'(READ_LATENCY);

    logic                  init_q;
    logic [31:0]           bram_addr_q;
    logic [31:0]           data_q, data_d;
    logic [2:0]            wait_q, wait_d;
    logic                  valid_q, valid_d;
    logic [7:0]            led_q, led_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [7:0]            an_q, an_d;

    logic                  addr_change;
    logic [15:0]           addr_lo;
    logic [15:0]           half_word;
    logic [3:0]            nibble;
    logic                  dp_on;
    logic [7:0]            dec_seg;

    // init_q makes the first cycle out of reset look like an address change.
    assign addr_change = init_q || (bram_addr_q != bram_addr);

    always_comb begin
        wait_d  = wait_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (addr_change) begin
            wait_d  = WAIT_LOAD;
            valid_d = 1'b0;
        end else if (wait_q != 3'd0) begin
            wait_d = wait_q - 3'd1;
            if (wait_q == 3'd1) begin
                data_d  = bram_dout;
                valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        led_d = led_q;
        if (valid_q) begin
            led_d = data_q[{byte_sel, 3'b000} +: 8];
        end
    end

    always_comb begin
        dwell_d = dwell_q + DWELL_W'(1);
        idx_d   = idx_q;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            idx_d   = idx_q + IDX_W'(1);
        end
    end

    // Segment content is built for idx_d so seg and an land on the same edge.
    assign addr_lo   = bram_addr_q[15:0];
    assign half_word = half_sel ? data_q[31:16] : data_q[15:0];
    assign nibble    = idx_d[2] ? addr_lo[{idx_d[1:0], 2'b00} +: 4]
                                : half_word[{idx_d[1:0], 2'b00} +: 4];
    assign dp_on     = (idx_d == IDX_W'(4));

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble),
        .dp_on_i  (dp_on),
        .seg_o    (dec_seg)
    );

    always_comb begin
        seg_d = dec_seg;
        if (!idx_d[2] && !valid_q) begin
            seg_d = SEG_DASH;
        end
        an_d = digit_enable(idx_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            init_q      <= 1'b1;
            bram_addr_q <= '0;
            data_q      <= '0;
            wait_q      <= '0;
            valid_q     <= 1'b0;
            led_q       <= '0;
            dwell_q     <= '0;
            idx_q       <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= AN_RESET;
        end else begin
            init_q      <= 1'b0;
            bram_addr_q <= bram_addr;
            data_q      <= data_d;
            wait_q      <= wait_d;
            valid_q     <= valid_d;
            led_q       <= led_d;
            dwell_q     <= dwell_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign led        = led_q;
    assign data_valid = valid_q;

endmodule
